// File: rtl/debounce_pkg.sv
// -----------------------------------------------------------------------------
// debounce_pkg
// Shared definitions for the button debouncer: FSM state encoding and the
// default counter width / qualification length used by debounce_fsm.
// -----------------------------------------------------------------------------
package debounce_pkg;

  localparam int DEFAULT_SIZE         = 4;
  localparam int DEFAULT_STABLE_COUNT = 4;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } state_e;

endpackage : debounce_pkg

// File: rtl/debounce_fsm_counter.sv
// -----------------------------------------------------------------------------
// debounce_fsm_counter
// Free-running up-counter with synchronous clear, used as the debouncer's
// stability counter.
//   i_clk       : clock, rising edge
//   i_reset     : synchronous active-high clear (count returns to 0)
//   i_increment : add one to the count on the next rising edge
//   o_count     : current count
// -----------------------------------------------------------------------------
module debounce_fsm_counter #(
  parameter int SIZE = 4
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_increment,
  output logic [SIZE-1:0] o_count
);

  logic [SIZE-1:0] count_d;
  logic [SIZE-1:0] count_q;

  always_comb begin
    count_d = count_q;
    if (i_increment) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign o_count = count_q;

endmodule : debounce_fsm_counter

// File: rtl/debounce_fsm.sv
// -----------------------------------------------------------------------------
// debounce_fsm
// Debounces a raw asynchronous push-button. The input is brought into the
// clock domain by a two-flop synchroniser; a four-state FSM then requires
// STABLE_COUNT+1 consecutive synchronised samples differing from the current
// level before the debounced level changes.
//   i_clk      : sole clock, rising edge
//   i_reset    : synchronous active-high reset
//   i_button   : raw bouncing button level (asynchronous)
//   o_level    : debounced level (registered)
//   o_pressed  : one-cycle pulse on debounced 0->1 (registered)
//   o_released : one-cycle pulse on debounced 1->0 (registered)
//   o_busy     : high while a candidate transition is being qualified
// -----------------------------------------------------------------------------
module debounce_fsm
  import debounce_pkg::*;
#(
  parameter int SIZE         = DEFAULT_SIZE,
  parameter int STABLE_COUNT = DEFAULT_STABLE_COUNT
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_button,
  output logic o_level,
  output logic o_pressed,
  output logic o_released,
  output logic o_busy
);

  // Count value seen on the edge that completes qualification.
  localparam logic [SIZE-1:0] LAST_CNT = SIZE'(STABLE_COUNT - 1);

  logic            sync1_d, sync1_q;
  logic            sync2_d, sync2_q;
  state_e          state_d, state_q;
  logic            level_d, level_q;
  logic            pressed_d, pressed_q;
  logic            released_d, released_q;
  logic            busy_d, busy_q;
  logic            inc;
  logic            clr;
  logic [SIZE-1:0] count;

  debounce_fsm_counter #(
    .SIZE (SIZE)
  ) u_counter (
    .i_clk       (i_clk),
    .i_reset     (i_reset | clr),
    .i_increment (inc),
    .o_count     (count)
  );

  always_comb begin
    sync1_d = i_button;
    sync2_d = sync1_q;
  end

  // Next-state logic. An abort (sync2 back at the current level) is tested
  // before the qualification compare so it wins on the qualifying edge.
  always_comb begin
    state_d = state_q;
    inc     = 1'b0;
    clr     = 1'b0;
    case (state_q)
      STABLE_LOW: begin
        clr = 1'b1;
        if (sync2_q) state_d = WAIT_HIGH;
      end
      WAIT_HIGH: begin
        if (!sync2_q) begin
          state_d = STABLE_LOW;
          clr     = 1'b1;
        end else if (count == LAST_CNT) begin
          state_d = STABLE_HIGH;
          clr     = 1'b1;
        end else begin
          inc = 1'b1;
        end
      end
      STABLE_HIGH: begin
        clr = 1'b1;
        if (!sync2_q) state_d = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (sync2_q) begin
          state_d = STABLE_HIGH;
          clr     = 1'b1;
        end else if (count == LAST_CNT) begin
          state_d = STABLE_LOW;
          clr     = 1'b1;
        end else begin
          inc = 1'b1;
        end
      end
      default: begin
        state_d = STABLE_LOW;
        clr     = 1'b1;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_comb begin
    level_d    = (state_d == STABLE_HIGH) || (state_d == WAIT_LOW);
    busy_d     = (state_d == WAIT_HIGH)   || (state_d == WAIT_LOW);
    pressed_d  = (state_q == WAIT_HIGH)   && (state_d == STABLE_HIGH);
    released_d = (state_q == WAIT_LOW)    && (state_d == STABLE_LOW);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      state_q    <= STABLE_LOW;
      level_q    <= 1'b0;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      state_q    <= state_d;
      level_q    <= level_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
      busy_q     <= busy_d;
    end
  end

  assign o_level    = level_q;
  assign o_pressed  = pressed_q;
  assign o_released = released_q;
  assign o_busy     = busy_q;

endmodule : debounce_fsm
